// File: rtl/pxl_src_gen.sv
// pxl_src_gen: programmable raster timing generator with selectable 24-bit test patterns.
module pxl_src_gen #(
  parameter int HSA  = 4,
  parameter int HBP  = 4,
  parameter int HACT = 16,
  parameter int HFP  = 4,
  parameter int VSA  = 2,
  parameter int VBP  = 2,
  parameter int VACT = 8,
  parameter int VFP  = 2
) (
  input  logic        pxl_clk,
  input  logic        pxl_rst,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_color,
  output logic        pxl_vsync,
  output logic        pxl_hsync,
  output logic [23:0] pxl_data,
  output logic        pxl_valid,
  output logic [15:0] pxl_no_pixels,
  output logic        frame_done,
  output logic        busy
);
  localparam int H_TOTAL = HSA + HBP + HACT + HFP;
  localparam int V_TOTAL = VSA + VBP + VACT + VFP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [HW-1:0] h_cnt, h_nx;
  logic [VW-1:0] v_cnt, v_nx;
  logic [1:0] sel_q, sel;
  logic [23:0] color_q, color, pix_cnt, pix_cur, pat;
  logic [15:0] x, np_cur;
  logic [2:0] bar;
  logic run, first, h_last, last, active;
  always_comb begin
    run = state == RUN;
    h_last = h_cnt == HW'(H_TOTAL - 1);
    last = h_last && v_cnt == VW'(V_TOTAL - 1);
    first = h_cnt == '0 && v_cnt == '0;
    active = h_cnt >= HW'(HSA + HBP) && h_cnt < HW'(HSA + HBP + HACT) &&
             v_cnt >= VW'(VSA + VBP) && v_cnt < VW'(VSA + VBP + VACT);
    x = 16'(h_cnt) - 16'(HSA + HBP);
    bar = 3'(x / 16'(HACT / 8));
    // Values latched at (0,0) must already apply to a pixel at (0,0)
    sel = first ? pattern_sel : sel_q;
    color = first ? solid_color : color_q;
    pix_cur = first ? '0 : pix_cnt;
    np_cur = first ? '0 : pxl_no_pixels;
    pat = sel == 2'd0 ? color :
          sel == 2'd1 ? {3{x[7:0]}} :
          sel == 2'd2 ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} : pix_cur;
    state_nx = !run ? (en ? RUN : IDLE) : (last && !en) ? IDLE : RUN;
    h_nx = (run && !h_last) ? h_cnt + 1'b1 : '0;
    v_nx = (!run || last) ? '0 : h_last ? v_cnt + 1'b1 : v_cnt;
  end
  always_ff @(posedge pxl_clk) begin
    if (pxl_rst) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
      sel_q <= '0;
      color_q <= '0;
      pix_cnt <= '0;
      pxl_vsync <= 1'b0;
      pxl_hsync <= 1'b0;
      pxl_data <= '0;
      pxl_valid <= 1'b0;
      pxl_no_pixels <= '0;
      frame_done <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_nx;
      h_cnt <= h_nx;
      v_cnt <= v_nx;
      if ((!run && en) || (run && first)) begin
        sel_q <= pattern_sel;
        color_q <= solid_color;
      end
      pxl_vsync <= run && v_cnt < VW'(VSA);
      pxl_hsync <= run && h_cnt < HW'(HSA);
      pxl_valid <= run && active;
      pxl_data <= (run && active) ? pat : '0;
      frame_done <= run && last;
      busy <= run;
      if (run) begin
        pix_cnt <= pix_cur + 24'(active);
        pxl_no_pixels <= np_cur + 16'(active);
      end
    end
  end
endmodule

// File: tb/tb_pxl_src_gen.sv
// tb_pxl_src_gen: scoreboard bench for pxl_src_gen (default raster plus a minimal raster instance).
module tb_pxl_src_gen;
  typedef struct packed {logic [23:0] d; logic [15:0] n;} exp_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, en2 = 1'b0;
  logic [1:0] sel = 2'd0, sel2 = 2'd0;
  logic [23:0] color = '0, color2 = 24'h00A5C3;
  logic vs, hs, valid, fd, busy, vs2, hs2, valid2, fd2, busy2;
  logic [23:0] data, data2;
  logic [15:0] np, np2;
  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0, last_fd = -1, nvs = 0, nhs = 0, nval = 0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  always #5 clk = ~clk;
  pxl_src_gen dut (
    .pxl_clk(clk), .pxl_rst(rst), .en(en), .pattern_sel(sel), .solid_color(color),
    .pxl_vsync(vs), .pxl_hsync(hs), .pxl_data(data), .pxl_valid(valid),
    .pxl_no_pixels(np), .frame_done(fd), .busy(busy)
  );
  pxl_src_gen #(.HSA(1), .HBP(0), .HACT(8), .HFP(0), .VSA(1), .VBP(0), .VACT(1), .VFP(0)) dut2 (
    .pxl_clk(clk), .pxl_rst(rst), .en(en2), .pattern_sel(sel2), .solid_color(color2),
    .pxl_vsync(vs2), .pxl_hsync(hs2), .pxl_data(data2), .pxl_valid(valid2),
    .pxl_no_pixels(np2), .frame_done(fd2), .busy(busy2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic push_frame(input logic [1:0] s, input logic [23:0] c);
    exp_t e;
    logic [7:0] x;
    for (int i = 0; i < 128; i++) begin
      x = 8'(i % 16);
      e.d = s == 2'd0 ? c : s == 2'd1 ? {x, x, x} : s == 2'd2 ? bars[x / 2] : 24'(i);
      e.n = 16'(i + 1);
      sb.push_back(e);
    end
  endtask
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (vs) nvs++;
    if (hs) nhs++;
    if (valid) begin
      nval++;
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        check("data", data, e.d);
        check("npix", np, e.n);
      end
    end else check("blank", data, 0);
    if (fd) begin
      check("vs_len", nvs, 56);
      check("hs_len", nhs, 56);
      check("nvalid", nval, 128);
      check("npix_end", np, 128);
      if (last_fd >= 0) check("period", cyc - last_fd, 392);
      last_fd = cyc;
      nvs = 0; nhs = 0; nval = 0;
    end
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic wait_fd();
    bit seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      tick();
      seen = fd;
    end
    if (!seen) check("fd_timeout", 0, 1);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_vs"}, vs, 0);
    check({tag, "_hs"}, hs, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_data"}, data, 0);
    check({tag, "_fd"}, fd, 0);
    check({tag, "_busy"}, busy, 0);
  endtask
  initial begin
    ticks(3);
    check_zero("rst");
    check("rst_npix", np, 0);
    rst = 1'b0;
    sel = 2'd0; color = 24'h123456; en = 1'b1;
    push_frame(2'd0, 24'h123456);
    tick();
    check("start_vs0", vs, 0);
    check("start_busy0", busy, 0);
    tick();
    check("start_vs1", vs, 1);
    check("start_hs1", hs, 1);
    check("start_busy1", busy, 1);
    ticks(20); sel = 2'd1; push_frame(2'd1, 24'h123456);
    wait_fd();
    ticks(20); sel = 2'd2; push_frame(2'd2, 24'h123456);
    wait_fd();
    ticks(20); sel = 2'd3; push_frame(2'd3, 24'h123456);
    wait_fd();
    ticks(20); push_frame(2'd3, 24'h123456);
    wait_fd();
    ticks(100); en = 1'b0;
    ticks(100); sel = 2'd1;
    wait_fd();
    last_fd = -1;
    tick();
    check_zero("stop");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stop_valid", valid, 0);
      check("stop_npix_hold", np, 128);
    end
    check("stop_sb_empty", sb.size(), 0);
    sel = 2'd0; color = 24'hABCDEF; en = 1'b1;
    push_frame(2'd0, 24'hABCDEF);
    tick();
    check("restart_vs0", vs, 0);
    tick();
    check("restart_vs1", vs, 1);
    check("restart_npix0", np, 0);
    ticks(148);
    rst = 1'b1;
    tick();
    check_zero("midrst");
    check("midrst_npix", np, 0);
    rst = 1'b0;
    sb.delete();
    nvs = 0; nhs = 0; nval = 0; last_fd = -1;
    push_frame(2'd0, 24'hABCDEF);
    tick();
    check("post_rst_vs0", vs, 0);
    tick();
    check("post_rst_vs1", vs, 1);
    check("post_rst_hs1", hs, 1);
    check("post_rst_npix0", np, 0);
    ticks(50); en = 1'b0;
    wait_fd();
    ticks(3);
    check("post_rst_sb_empty", sb.size(), 0);
    en2 = 1'b1;
    tick();
    check("small_edge1_vs", vs2, 0);
    for (int k = 0; k < 54; k++) begin
      tick();
      check("small_vs", vs2, (k % 18) < 9);
      check("small_hs", hs2, (k % 9) == 0);
      check("small_valid", valid2, (k % 18) >= 10);
      check("small_data", data2, (k % 18) >= 10 ? 24'h00A5C3 : 24'h0);
      check("small_fd", fd2, (k % 18) == 17);
      if ((k % 18) == 17) check("small_npix", np2, 8);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
